// File: rtl/hilo_muldiv_ctrl_pkg.sv
// Package: hilo_muldiv_ctrl_pkg
//   Shared op_sel codes, FSM state encoding and small decode helpers for the
//   HI/LO multiply/divide controller.
package hilo_muldiv_ctrl_pkg;

    typedef enum logic [1:0] {
        MULDIV_MULT  = 2'b00,
        MULDIV_MULTU = 2'b01,
        MULDIV_DIV   = 2'b10,
        MULDIV_DIVU  = 2'b11
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == MULDIV_MULT) || (op == MULDIV_DIV);
    endfunction

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == MULDIV_DIV) || (op == MULDIV_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Module: muldiv_iter_core
//   Iterative unsigned datapath: one shift-add multiply step or one restoring
//   divide step per 'step' cycle, WIDTH steps per operation.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       load a into the low half of the accumulator, b into the operand reg
//   step        perform one iteration (mode chosen by div_mode)
//   div_mode    1 = restoring divide, 0 = shift-add multiply
//   a, b        unsigned magnitudes (multiplicand/dividend, multiplier/divisor)
//   acc         2*WIDTH accumulator; after WIDTH steps holds product, or
//               {remainder, quotient} for divide
module muldiv_iter_core #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 step,
    input  logic                 div_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   acc
);

    logic [WIDTH-1:0]   b_q;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] div_next;

    always_comb begin
        // Multiply: add b into the upper half when the current LSB is set,
        // then shift the whole accumulator right, keeping the carry.
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_q} : '0);
        mul_next = {mul_sum, acc[WIDTH-1:1]};

        // Divide: remainder shifted left with the next dividend bit; the
        // remainder is always below b, so WIDTH+1 bits cover the trial.
        rem_sh = acc[2*WIDTH-1:WIDTH-1];
        trial  = rem_sh - {1'b0, b_q};
        if (!trial[WIDTH]) begin
            div_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            div_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            b_q <= '0;
        end else if (start) begin
            acc <= {{WIDTH{1'b0}}, a};
            b_q <= b;
        end else if (step) begin
            acc <= div_mode ? div_next : mul_next;
        end
    end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// Module: hilo_muldiv_ctrl
//   Owns HI/LO and sequences MULT/MULTU/DIV/DIVU over WIDTH cycles in EX,
//   stalling the pipeline while running and committing a sign-corrected
//   result to HI/LO. Also applies MTHI/MTLO writes while idle.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   op_valid, op_sel    mul/div instruction present in EX and its opcode
//   src_a, src_b        rs / rt operands
//   flush               EX flush, aborts accept or run
//   hi_we, lo_we        MTHI / MTLO enables, mt_data is the write value
//   stall               hold IF..EX (combinational)
//   result_valid        1-cycle pulse in DONE, HI/LO commit on its edge
//   div_by_zero         pulses with result_valid for a divide by zero
//   hi_o, lo_o          registered HI / LO
module hilo_muldiv_ctrl
    import hilo_muldiv_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    input  logic [1:0]       op_sel,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] mt_data,
    output logic             stall,
    output logic             result_valid,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int unsigned CW = $clog2(WIDTH);

    state_e             state;
    logic [CW-1:0]      cnt;
    logic               is_div_q;
    logic               neg_a_q;
    logic               neg_b_q;
    logic               b_zero_q;
    logic               accept;
    logic               sgn;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    assign accept = (state == ST_IDLE) && op_valid && !flush;
    assign stall  = accept || (state == ST_RUN);
    assign sgn    = op_is_signed(op_sel);
    assign a_mag  = (sgn && src_a[WIDTH-1]) ? -src_a : src_a;
    assign b_mag  = (sgn && src_b[WIDTH-1]) ? -src_b : src_b;

    muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (accept),
        .step     (state == ST_RUN),
        .div_mode (is_div_q),
        .a        (a_mag),
        .b        (b_mag),
        .acc      (acc)
    );

    // Sign fix-up; a divide by zero commits the raw core result
    // (quotient all ones, remainder = latched dividend).
    always_comb begin
        res_hi = acc[2*WIDTH-1:WIDTH];
        res_lo = acc[WIDTH-1:0];
        if (!is_div_q) begin
            if (neg_a_q ^ neg_b_q) begin
                {res_hi, res_lo} = -acc;
            end
        end else if (!b_zero_q) begin
            if (neg_a_q ^ neg_b_q) res_lo = -acc[WIDTH-1:0];
            if (neg_a_q)           res_hi = -acc[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            is_div_q     <= 1'b0;
            neg_a_q      <= 1'b0;
            neg_b_q      <= 1'b0;
            b_zero_q     <= 1'b0;
            hi_o         <= '0;
            lo_o         <= '0;
            result_valid <= 1'b0;
            div_by_zero  <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            div_by_zero  <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state    <= ST_RUN;
                        cnt      <= '0;
                        is_div_q <= op_is_div(op_sel);
                        neg_a_q  <= sgn && src_a[WIDTH-1];
                        neg_b_q  <= sgn && src_b[WIDTH-1];
                        b_zero_q <= (src_b == '0);
                    end else if (!op_valid) begin
                        if (hi_we) hi_o <= mt_data;
                        if (lo_we) lo_o <= mt_data;
                    end
                end
                ST_RUN: begin
                    if (flush) begin
                        state <= ST_IDLE;
                    end else if (cnt == CW'(WIDTH - 1)) begin
                        state        <= ST_DONE;
                        result_valid <= 1'b1;
                        div_by_zero  <= is_div_q && b_zero_q;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    hi_o  <= res_hi;
                    lo_o  <= res_lo;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
module tb_hilo_muldiv_ctrl;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        op_valid;
    logic [1:0]  op_sel;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] mt_data;
    logic        stall;
    logic        result_valid;
    logic        div_by_zero;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int errors = 0;
    int checks = 0;
    exp_t expq[$];
    exp_t cur;
    bit pend = 0;
    logic [31:0] mhi = '0;
    logic [31:0] mlo = '0;

    hilo_muldiv_ctrl #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .op_valid     (op_valid),
        .op_sel       (op_sel),
        .src_a        (src_a),
        .src_b        (src_b),
        .flush        (flush),
        .hi_we        (hi_we),
        .lo_we        (lo_we),
        .mt_data      (mt_data),
        .stall        (stall),
        .result_valid (result_valid),
        .div_by_zero  (div_by_zero),
        .hi_o         (hi_o),
        .lo_o         (lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [63:0] p;
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.dbz = 1'b0;
        p = (op == 2'b00) ? 64'(sa * sb) : ({32'b0, a} * {32'b0, b});
        e.hi = p[63:32];
        e.lo = p[31:0];
        if (op[1]) begin
            if (b == 0) begin
                e.dbz = 1'b1;
                e.lo  = '1;
                e.hi  = (op == 2'b10 && a[31]) ? -a : a;
            end else if (op == 2'b10) begin
                e.lo = 32'(sa / sb);
                e.hi = 32'(sa % sb);
            end else begin
                e.lo = a / b;
                e.hi = a % b;
            end
        end
        return e;
    endfunction

    // Scoreboard consumer: dbz checked in DONE, HI/LO one cycle later.
    always @(negedge clk) begin
        if (pend) begin
            check("commit_hi", hi_o, cur.hi);
            check("commit_lo", lo_o, cur.lo);
            pend = 0;
        end
        if (result_valid) begin
            if (expq.size() == 0) begin
                check("unexpected_result_valid", result_valid, 1'b0);
            end else begin
                cur = expq.pop_front();
                check("div_by_zero", div_by_zero, cur.dbz);
                pend = 1;
            end
        end else if (div_by_zero) begin
            check("dbz_without_valid", div_by_zero, 1'b0);
        end
    end

    always @(posedge clk) begin
        if (rst_n)
            assert (!(op_valid && (hi_we || lo_we))) else $error("mt write with op_valid");
    end

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int abort_at, input bit use_reset, input bit mt_in_run,
                          input bit flush_done);
        exp_t e;
        int n;
        bit aborted;
        e = model(op, a, b);
        @(negedge clk);
        flush = 0; op_valid = 1; op_sel = op; src_a = a; src_b = b;
        #1;
        check("stall_accept", stall, 1'b1);
        if (abort_at < 0) expq.push_back(e);
        n = 0;
        aborted = 0;
        while (n < 100) begin
            if (mt_in_run && n == 6) begin
                hi_we = 0; lo_we = 0; op_valid = 1;
                check("mt_run_hi", hi_o, mhi);
                check("mt_run_lo", lo_o, mlo);
            end
            if (mt_in_run && n == 5) begin
                op_valid = 0; hi_we = 1; lo_we = 1; mt_data = 32'hDEADBEEF;
            end
            if (abort_at >= 0 && n == abort_at + 1) begin
                if (use_reset) begin
                    rst_n = 0; op_valid = 0;
                    #1;
                    check("rst_run_hi", hi_o, 32'h0);
                    check("rst_run_lo", lo_o, 32'h0);
                    check("rst_run_stall", stall, 1'b0);
                    mhi = '0; mlo = '0;
                    @(negedge clk);
                    rst_n = 1;
                    return;
                end
                flush = 1; op_valid = 0; aborted = 1;
            end
            @(negedge clk);
            n++;
            flush = 0;
            if (!stall) break;
        end
        if (aborted) begin
            check("flush_stall_cycles", n, abort_at + 2);
            check("flush_keep_hi", hi_o, mhi);
            check("flush_keep_lo", lo_o, mlo);
        end else begin
            check("stall_cycles", n, 33);
            mhi = e.hi; mlo = e.lo;
            op_valid = 0;
            if (flush_done) begin
                flush = 1;
                @(negedge clk);
                flush = 0;
            end
        end
    endtask

    task automatic mt_write(input bit wh, input bit wl, input logic [31:0] d);
        @(negedge clk);
        flush = 0; op_valid = 0; hi_we = wh; lo_we = wl; mt_data = d;
        @(negedge clk);
        hi_we = 0; lo_we = 0;
        if (wh) mhi = d;
        if (wl) mlo = d;
        check("mt_hi", hi_o, mhi);
        check("mt_lo", lo_o, mlo);
    endtask

    initial begin
        rst_n = 0; op_valid = 0; op_sel = '0; src_a = '0; src_b = '0;
        flush = 0; hi_we = 0; lo_we = 0; mt_data = '0;
        repeat (2) @(negedge clk);
        check("reset_hi", hi_o, 32'h0);
        check("reset_lo", lo_o, 32'h0);
        check("reset_stall", stall, 1'b0);
        check("reset_rv", result_valid, 1'b0);
        check("reset_dbz", div_by_zero, 1'b0);
        rst_n = 1;

        run_op(2'b00, 32'hFFFFFFFD, 32'd5, -1, 0, 0, 0);
        run_op(2'b11, 32'd100, 32'd7, -1, 0, 0, 0);
        run_op(2'b10, 32'hFFFFFFF9, 32'd2, -1, 0, 0, 0);
        run_op(2'b11, 32'h00001234, 32'd0, -1, 0, 0, 0);
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, -1, 0, 0, 0);
        run_op(2'b10, 32'hFFFFFF9C, 32'hFFFFFFF9, -1, 0, 1, 0);
        run_op(2'b00, 32'h80000000, 32'h80000000, -1, 0, 0, 1);
        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 10, 0, 0, 0);

        mt_write(1, 0, 32'hA5A5A5A5);
        mt_write(0, 1, 32'h5A5A5A5A);

        // flush in IDLE with op_valid: never accepted
        @(negedge clk);
        op_valid = 1; flush = 1; op_sel = 2'b00; src_a = 32'd3; src_b = 32'd3;
        #1;
        check("idle_flush_stall", stall, 1'b0);
        @(negedge clk);
        op_valid = 0; flush = 0;
        check("idle_flush_stay_idle", stall, 1'b0);

        for (int i = 0; i < 4; i++) begin
            run_op(2'($urandom_range(0, 3)), $urandom, $urandom_range(0, 3) == 0 ? $urandom_range(1, 9) : $urandom,
                   -1, 0, 0, 0);
        end

        run_op(2'b00, 32'd12345, 32'hFFFFFD5A, 20, 1, 0, 0);

        run_op(2'b00, 32'd7, 32'hFFFFFFF7, -1, 0, 0, 0);
        run_op(2'b10, 32'd1000, 32'hFFFFFFFD, -1, 0, 0, 0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", expq.size(), 0);
        check("final_hi", hi_o, mhi);
        check("final_lo", lo_o, mlo);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
